// File: rtl/mvp_apb_arb_pkg.sv
// Shared types and constants for the two-requester APB3 arbiter.
package mvp_apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } arb_state_e;

  localparam int TO_CYC_DEFAULT = 256;

  // Timeout counter width: wide enough for TO_CYC, never narrower than 8 bits.
  function automatic int to_cnt_width(input int cyc);
    int w;
    w = $clog2(cyc);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/mvp_rr_arb2.sv
// Two-way round-robin grant: combinational one-hot grant, registered last-winner pointer.
module mvp_rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       update,
  output logic [1:0] gnt
);

  logic ptr_r;

  // Last-winner pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_r <= 1'b1;
    end else if (update) begin
      ptr_r <= last_grant;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Grant the sole requester, or on a tie the one that did not win last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mvp_apb_arbiter.sv
// Shares one APB3 master port between two APB3 requesters, one transfer at a time.
// Optional ACCESS-phase timeout enabled by defining MVP_APB_ARB_TIMEOUT_EN.
module mvp_apb_arbiter
  import mvp_apb_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = TO_CYC_DEFAULT
) (
  input  logic          i_clk_si,
  input  logic          i_rstn_si,
  input  logic          i_s0_psel,
  input  logic          i_s0_penable,
  input  logic          i_s0_pwrite,
  input  logic [AW-1:0] i_s0_paddr,
  input  logic [DW-1:0] i_s0_pwdata,
  output logic [DW-1:0] o_s0_prdata,
  output logic          o_s0_pready,
  output logic          o_s0_pslverr,
  input  logic          i_s1_psel,
  input  logic          i_s1_penable,
  input  logic          i_s1_pwrite,
  input  logic [AW-1:0] i_s1_paddr,
  input  logic [DW-1:0] i_s1_pwdata,
  output logic [DW-1:0] o_s1_prdata,
  output logic          o_s1_pready,
  output logic          o_s1_pslverr,
  output logic          o_mi_psel,
  output logic          o_mi_penable,
  output logic          o_mi_pwrite,
  output logic [AW-1:0] o_mi_paddr,
  output logic [DW-1:0] o_mi_pwdata,
  input  logic [DW-1:0] i_mi_prdata,
  input  logic          i_mi_pready,
  input  logic          i_mi_pslverr,
  output logic          o_busy
);

  arb_state_e    state_r, state_nxt_s;
  logic [1:0]    gnt_s;
  logic          gidx_r;
  logic          psel_r, penable_r, pwrite_r;
  logic [AW-1:0] paddr_r;
  logic [DW-1:0] pwdata_r;
  logic          timeout_s;
  logic          done_s;
  logic          rsp_ready_s, rsp_err_s;
  logic [DW-1:0] rsp_data_s;

  // Requester penable is not needed: the access phase has begun before any response returns.
  logic unused_s;
  assign unused_s = &{1'b0, i_s0_penable, i_s1_penable};

  mvp_rr_arb2 u_rr (
    .clk        (i_clk_si),
    .rstn       (i_rstn_si),
    .req        ({i_s1_psel, i_s0_psel}),
    .last_grant (gidx_r),
    .update     (done_s),
    .gnt        (gnt_s)
  );

`ifdef MVP_APB_ARB_TIMEOUT_EN
  localparam int CW = to_cnt_width(TO_CYC);
  logic [CW-1:0] cnt_r;

  // Counts ACCESS cycles without pready; cleared while in SETUP.
  always_ff @(posedge i_clk_si) begin
    if (!i_rstn_si) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_SETUP) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_ACCESS) && !i_mi_pready) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_s = (state_r == ST_ACCESS) && !i_mi_pready && (cnt_r == CW'(TO_CYC - 1));
`else
  localparam int unused_to_cyc = TO_CYC;
  assign timeout_s = 1'b0;
`endif

  assign done_s = (state_r == ST_ACCESS) && (i_mi_pready || timeout_s);
  assign o_busy = (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge i_clk_si) begin
    if (!i_rstn_si) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   state_nxt_s = (|gnt_s) ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: state_nxt_s = done_s ? ST_IDLE : ST_ACCESS;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Master-port registers; address/data/direction hold their last value while idle.
  always_ff @(posedge i_clk_si) begin
    if (!i_rstn_si) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= {AW{1'b0}};
      pwdata_r  <= {DW{1'b0}};
      gidx_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_s[0]) begin
            psel_r   <= 1'b1;
            pwrite_r <= i_s0_pwrite;
            paddr_r  <= i_s0_paddr;
            pwdata_r <= i_s0_pwdata;
            gidx_r   <= 1'b0;
          end else if (gnt_s[1]) begin
            psel_r   <= 1'b1;
            pwrite_r <= i_s1_pwrite;
            paddr_r  <= i_s1_paddr;
            pwdata_r <= i_s1_pwdata;
            gidx_r   <= 1'b1;
          end else begin
            psel_r <= 1'b0;
          end
        end
        ST_SETUP: penable_r <= 1'b1;
        ST_ACCESS: begin
          if (done_s) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
          end else begin
            penable_r <= 1'b1;
          end
        end
        default: begin
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_mi_psel    = psel_r;
  assign o_mi_penable = penable_r;
  assign o_mi_pwrite  = pwrite_r;
  assign o_mi_paddr   = paddr_r;
  assign o_mi_pwdata  = pwdata_r;

  // Response demux: only the granted requester sees the completion; a real pready beats a timeout.
  always_comb begin
    rsp_ready_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = {DW{1'b0}};
    if ((state_r == ST_ACCESS) && i_mi_pready) begin
      rsp_ready_s = 1'b1;
      rsp_err_s   = i_mi_pslverr;
      rsp_data_s  = i_mi_prdata;
    end else if (timeout_s) begin
      rsp_ready_s = 1'b1;
      rsp_err_s   = 1'b1;
      rsp_data_s  = {DW{1'b0}};
    end else begin
      rsp_ready_s = 1'b0;
    end
    o_s0_pready  = rsp_ready_s & ~gidx_r;
    o_s0_pslverr = rsp_err_s & ~gidx_r;
    o_s0_prdata  = gidx_r ? {DW{1'b0}} : rsp_data_s;
    o_s1_pready  = rsp_ready_s & gidx_r;
    o_s1_pslverr = rsp_err_s & gidx_r;
    o_s1_prdata  = gidx_r ? rsp_data_s : {DW{1'b0}};
  end

endmodule

// File: tb/tb_mvp_apb_arbiter.sv
// Scoreboard bench for mvp_apb_arbiter: directed transfers, responses checked by a monitor.
module tb_mvp_apb_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s0_psel = 1'b0, s0_penable = 1'b0, s0_pwrite = 1'b0;
  logic [31:0] s0_paddr = 32'h0, s0_pwdata = 32'h0;
  logic        s1_psel = 1'b0, s1_penable = 1'b0, s1_pwrite = 1'b0;
  logic [31:0] s1_paddr = 32'h0, s1_pwdata = 32'h0;
  logic [31:0] o_s0_prdata, o_s1_prdata;
  logic        o_s0_pready, o_s0_pslverr, o_s1_pready, o_s1_pslverr;
  logic        o_mi_psel, o_mi_penable, o_mi_pwrite, o_busy;
  logic [31:0] o_mi_paddr, o_mi_pwdata;
  logic [31:0] mi_prdata = 32'h0;
  logic        mi_pready = 1'b0, mi_pslverr = 1'b0;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int wait_cfg = 0;
  bit err_cfg = 1'b0;
  bit hang = 1'b0;
  int wcnt = 0;

  mvp_apb_arbiter #(.AW(32), .DW(32), .TO_CYC(16)) dut (
    .i_clk_si(clk), .i_rstn_si(rstn),
    .i_s0_psel(s0_psel), .i_s0_penable(s0_penable), .i_s0_pwrite(s0_pwrite),
    .i_s0_paddr(s0_paddr), .i_s0_pwdata(s0_pwdata),
    .o_s0_prdata(o_s0_prdata), .o_s0_pready(o_s0_pready), .o_s0_pslverr(o_s0_pslverr),
    .i_s1_psel(s1_psel), .i_s1_penable(s1_penable), .i_s1_pwrite(s1_pwrite),
    .i_s1_paddr(s1_paddr), .i_s1_pwdata(s1_pwdata),
    .o_s1_prdata(o_s1_prdata), .o_s1_pready(o_s1_pready), .o_s1_pslverr(o_s1_pslverr),
    .o_mi_psel(o_mi_psel), .o_mi_penable(o_mi_penable), .o_mi_pwrite(o_mi_pwrite),
    .o_mi_paddr(o_mi_paddr), .o_mi_pwdata(o_mi_pwdata),
    .i_mi_prdata(mi_prdata), .i_mi_pready(mi_pready), .i_mi_pslverr(mi_pslverr),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h5500_0000: return 32'h0000_0011;
      32'h5600_0004: return 32'h0000_0022;
      default:       return 32'hBAD0_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %b required %b", name, act, req);
  endtask

  task automatic expect_rsp(input int idx, input logic [31:0] rdata, input logic err,
                            input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.err = err; e.wr = wr; e.addr = addr; e.wdata = wdata;
    sbq.push_back(e);
  endtask

  task automatic drive(input int n, input logic sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      s0_psel = sel; s0_penable = en; s0_pwrite = wr; s0_paddr = a; s0_pwdata = d;
    end else begin
      s1_psel = sel; s1_penable = en; s1_pwrite = wr; s1_paddr = a; s1_pwdata = d;
    end
  endtask

  // One APB3 requester transfer; starts and ends on a falling edge.
  task automatic s_xfer(input int n, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic done;
    done = 1'b0;
    drive(n, 1'b1, 1'b0, wr, a, d);
    @(negedge clk);
    drive(n, 1'b1, 1'b1, wr, a, d);
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      if ((n == 0) ? o_s0_pready : o_s1_pready) done = 1'b1;
      else @(negedge clk);
    end
    chk1("xfer_completes", done, 1'b1);
    @(negedge clk);
    drive(n, 1'b0, 1'b0, wr, a, d);
  endtask

  task automatic wait_pen();
    int k;
    k = 0;
    do begin
      @(negedge clk); #3;
      k++;
    end while (!o_mi_penable && k < 50);
    chk1("penable_seen", o_mi_penable, 1'b1);
  endtask

  // Downstream slave model: wait_cfg wait states, then pready with err_cfg.
  initial begin
    forever begin
      @(negedge clk);
      if (o_mi_psel && o_mi_penable && !hang) begin
        if (wcnt == wait_cfg) begin
          mi_pready = 1'b1;
          mi_prdata = o_mi_pwrite ? 32'h0 : rd_model(o_mi_paddr);
          mi_pslverr = err_cfg;
          wcnt = 0;
        end else begin
          mi_pready = 1'b0; mi_prdata = 32'h0; mi_pslverr = 1'b0;
          wcnt++;
        end
      end else begin
        mi_pready = 1'b0; mi_prdata = 32'h0; mi_pslverr = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every requester completion.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (o_s0_pready || o_s1_pready) begin
        chk1("pready_onehot", o_s0_pready & o_s1_pready, 1'b0);
        chk1("sb_has_entry", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          chk("rsp_idx", o_s1_pready ? 32'd1 : 32'd0, mon_e.idx);
          chk("rsp_prdata", o_s1_pready ? o_s1_prdata : o_s0_prdata, mon_e.rdata);
          chk1("rsp_pslverr", o_s1_pready ? o_s1_pslverr : o_s0_pslverr, mon_e.err);
          chk1("mi_pwrite", o_mi_pwrite, mon_e.wr);
          chk("mi_paddr", o_mi_paddr, mon_e.addr);
          chk("mi_pwdata", o_mi_pwdata, mon_e.wdata);
        end
      end
      if (!o_s0_pready) chk("s0_quiet", o_s0_prdata | {31'h0, o_s0_pslverr}, 32'h0);
      if (!o_s1_pready) chk("s1_quiet", o_s1_prdata | {31'h0, o_s1_pslverr}, 32'h0);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #3;
    chk1("rst_psel", o_mi_psel, 1'b0);
    chk1("rst_penable", o_mi_penable, 1'b0);
    chk1("rst_pwrite", o_mi_pwrite, 1'b0);
    chk("rst_paddr", o_mi_paddr, 32'h0);
    chk("rst_pwdata", o_mi_pwdata, 32'h0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_s0_pready", o_s0_pready, 1'b0);
    chk1("rst_s1_pready", o_s1_pready, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // Simultaneous reads after reset: s0 first, one idle cycle, then s1.
    expect_rsp(0, 32'h0000_0011, 1'b0, 1'b0, 32'h5500_0000, 32'h0);
    expect_rsp(1, 32'h0000_0022, 1'b0, 1'b0, 32'h5600_0004, 32'h0);
    fork
      s_xfer(0, 1'b0, 32'h5500_0000, 32'h0);
      s_xfer(1, 1'b0, 32'h5600_0004, 32'h0);
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk); #3;
          k++;
        end while (!o_s0_pready && k < 20);
        chk1("tie_s0_first", o_s0_pready, 1'b1);
        @(negedge clk); #3;
        chk1("gap_psel", o_mi_psel, 1'b0);
        chk1("gap_busy", o_busy, 1'b0);
        @(negedge clk); #3;
        chk1("second_psel", o_mi_psel, 1'b1);
        chk("second_paddr", o_mi_paddr, 32'h5600_0004);
      end
    join
    repeat (2) @(negedge clk);

    // Continuous writes from both: grants alternate s0,s1,s0,s1,s0,s1.
    for (int i = 0; i < 3; i++) begin
      expect_rsp(0, 32'h0, 1'b0, 1'b1, 32'h5500_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      expect_rsp(1, 32'h0, 1'b0, 1'b1, 32'h5600_0200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    end
    fork
      for (int i = 0; i < 3; i++) s_xfer(0, 1'b1, 32'h5500_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      for (int j = 0; j < 3; j++) s_xfer(1, 1'b1, 32'h5600_0200 + 32'(4 * j), 32'hB000_0000 + 32'(j));
    join
    repeat (2) @(negedge clk);

    // Single s0 write, immediate pready: latency check.
    expect_rsp(0, 32'h0, 1'b0, 1'b1, 32'h5500_0010, 32'hDEAD_BEEF);
    fork
      s_xfer(0, 1'b1, 32'h5500_0010, 32'hDEAD_BEEF);
      begin
        @(negedge clk); #3;
        chk1("lat_psel", o_mi_psel, 1'b1);
        chk1("lat_penable0", o_mi_penable, 1'b0);
        chk1("lat_busy", o_busy, 1'b1);
        @(negedge clk); #3;
        chk1("lat_penable1", o_mi_penable, 1'b1);
        chk1("lat_s0_pready", o_s0_pready, 1'b1);
        chk1("lat_s1_pready", o_s1_pready, 1'b0);
        @(negedge clk); #3;
        chk1("lat_psel_drop", o_mi_psel, 1'b0);
        chk1("lat_s0_pready_drop", o_s0_pready, 1'b0);
      end
    join
    repeat (2) @(negedge clk);

    // s1 write with 3 wait states and pslverr.
    wait_cfg = 3; err_cfg = 1'b1;
    expect_rsp(1, 32'h0, 1'b1, 1'b1, 32'h5600_0008, 32'h1234_5678);
    fork
      s_xfer(1, 1'b1, 32'h5600_0008, 32'h1234_5678);
      begin
        wait_pen();
        for (int i = 0; i < 3; i++) begin
          chk("ws_paddr", o_mi_paddr, 32'h5600_0008);
          chk("ws_pwdata", o_mi_pwdata, 32'h1234_5678);
          chk1("ws_psel", o_mi_psel & o_mi_penable & o_mi_pwrite, 1'b1);
          chk1("ws_s1_pslverr", o_s1_pslverr, 1'b0);
          @(negedge clk); #3;
        end
        chk1("ws_s1_pslverr_rdy", o_s1_pslverr, 1'b1);
      end
    join
    wait_cfg = 0; err_cfg = 1'b0;
    repeat (2) @(negedge clk);

    // Sync reset during ACCESS drops the master port without a completion.
    hang = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 32'h5500_0030, 32'h0);
    wait_pen();
    rstn = 1'b0;
    @(negedge clk); #3;
    chk1("rstx_psel", o_mi_psel, 1'b0);
    chk1("rstx_penable", o_mi_penable, 1'b0);
    chk1("rstx_busy", o_busy, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h5500_0030, 32'h0);
    rstn = 1'b1;
    hang = 1'b0;
    repeat (2) @(negedge clk);

`ifdef MVP_APB_ARB_TIMEOUT_EN
    // Downstream never responds: timeout completion in the 16th ACCESS cycle.
    hang = 1'b1;
    expect_rsp(0, 32'h0, 1'b1, 1'b0, 32'h5500_0040, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h5500_0040, 32'h0);
    wait_pen();
    begin
      int n;
      n = 1;
      while (!o_s0_pready && n < 40) begin
        @(negedge clk); #3;
        n++;
      end
      chk("to_access_cycles", 32'(n), 32'd16);
      chk1("to_pslverr", o_s0_pslverr, 1'b1);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h5500_0040, 32'h0);
    hang = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
